bar_fifo: RTL and testbench
===========================

# bar_fifo

Synchronous FIFO stage that sits directly downstream of any module driving a `bar` interface. It accepts 32-bit `data` words on an upstream `bar` port using the valid/ready handshake, buffers up to DEPTH words, and re-issues them in order on a downstream `bar` port. It decouples producer and consumer timing, and has no combinational path from `out.ready` to `in.ready`.

## Interface
- DEPTH, default 4: number of entries; must be a power of two and at least 2.
- CW, default $clog2(DEPTH+1): width of the `count` output. This is derived; do not override.

- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, synchronous and active-high
- in   bar (consumer side)  —  upstream stream
  - in.data  input  32  word offered by upstream
  - in.valid  input  1  upstream offers a word
  - in.ready  output  1  FIFO can accept a word this cycle
- out  bar (producer side)  —  downstream stream
  - out.data  output  32  head-of-queue word
  - out.valid  output  1  FIFO is non-empty
  - out.ready  input  1  downstream accepts the word this cycle
- count  output  CW  current occupancy, 0..DEPTH
- stall_cnt  output  32  present only with BAR_FIFO_STATS_EN

## Operation
- Storage: DEPTH x 32 register array, a write pointer `wp`, a read pointer `rp`, and an occupancy counter `count`. The pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
- Push: fires when `in.valid && in.ready`. Writes `mem[wp] <= in.data` and increments `wp`.
- Pop: fires when `out.valid && out.ready`. Increments `rp`.
- Count update: push only → +1; pop only → −1; push and pop in the same cycle → unchanged, both pointers advance.
- Output flags:
  - `in.ready = !rst && (count != DEPTH)`. This depends only on registered state; it never depends on `out.ready`.
  - `out.valid = (count != 0)`.
  - `out.data = out.valid ? mem[rp] : 32'h0`.
- Full: `in.ready` is 0, so no push happens even if a pop occurs that same cycle. The slot frees up on the following cycle.
- Empty: `out.valid` is 0, so no pop happens. A simultaneous push on an empty FIFO does not bypass to the output.
- `in.data` is ignored whenever `in.valid` is 0 or `in.ready` is 0.
- Ordering is strictly FIFO. Nothing is dropped or duplicated.
- Reset (synchronous, any cycle, including mid-stream):
  - `wp`, `rp` and `count` are cleared to 0. The array contents are not reset.
  - Any push or pop requested in the reset cycle is discarded.
  - Outputs while `rst` is high and in the first cycle after it: `in.ready` = 0 during reset, then 1; `out.valid` = 0; `out.data` = 0; `count` = 0; `stall_cnt` = 0.

## Timing
- Latency: a word pushed in cycle N appears on `out` in cycle N+1, with `out.valid` = 1.
- Throughput: one word per cycle sustained when `out.ready` is held at 1.
- Occupancy: the FIFO holds DEPTH words. `in.ready` deasserts in the cycle after the DEPTH-th push when there is no pop.
- `count` reflects state as of the last clock edge.
- Producer contract: upstream must hold `in.data` stable while `in.valid && !in.ready`. The FIFO itself does not rely on this.
- Output stability: the FIFO guarantees `out.data` and `out.valid` remain stable while `out.valid && !out.ready`.

## Configuration
- Macro: `BAR_FIFO_STATS_EN`.
- Defined:
  - Adds the `stall_cnt` port, a 32-bit counter.
  - Increments each cycle `out.valid && !out.ready` holds.
  - Saturates at 32'hFFFF_FFFF.
  - Synchronously cleared by `rst`.
- Not defined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Reset then single word:
  - Hold `rst` for 2 cycles, push 32'd42 with `out.ready` = 0.
  - Required: next cycle `out.valid` = 1, `out.data` = 42, `count` = 1.
  - Raise `out.ready`: next cycle `count` = 0 and `out.data` = 0.
- Fill to full, DEPTH = 4, `out.ready` = 0:
  - Push 1, 2, 3, 4. Required: `count` = 4 and `in.ready` = 0.
  - Offer 5. Required: it is not accepted.
  - Drain. Required: 1, 2, 3, 4 in order, and `in.ready` = 1 the cycle after the first pop.
- Streaming:
  - `in.valid` and `out.ready` held at 1 for 20 cycles with data 0..19.
  - Required: output 0..19 with one cycle of latency, `count` constant at 1, no bubbles.
- Wrap-around:
  - 3 rounds of push-4 then pop-4, data 9001+i.
  - Required: output order preserved across pointer wrap; `count` returns to 0 each round.
- Reset mid-operation:
  - Push 1337 and 7, then assert `rst` in the same cycle as a push of 9.
  - Required: after reset `count` = 0 and `out.valid` = 0, and 9 never appears on the output.
- With `BAR_FIFO_STATS_EN`:
  - Push 1 word, hold `out.ready` = 0 for 5 cycles, then pop.
  - Required: `stall_cnt` = 5, and `stall_cnt` = 0 after `rst`.

Source files
------------

// File: rtl/bar_fifo.sv
// bar_fifo: DEPTH-entry valid/ready FIFO stage; in_ready depends only on registered state.
// Optional stall counter output stall_cnt is enabled by defining BAR_FIFO_STATS_EN.
module bar_fifo #(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef BAR_FIFO_STATS_EN
    output logic [31:0]   stall_cnt,
`endif
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          push, pop;

    // Outputs are forced idle while rst is high so a mid-stream reset never leaks stale state.
    always_comb begin
        in_ready  = !rst && (cnt != CW'(DEPTH));
        out_valid = !rst && (cnt != '0);
        out_data  = out_valid ? mem[rp] : 32'h0;
        count     = rst ? '0 : cnt;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

`ifdef BAR_FIFO_STATS_EN
    logic [31:0] stall;

    always_ff @(posedge clk) begin
        if (rst)
            stall <= '0;
        else if (out_valid && !out_ready && stall != '1)
            stall <= stall + 1'b1;
    end

    assign stall_cnt = rst ? 32'h0 : stall;
`endif
endmodule

// File: tb/tb_bar_fifo.sv
// tb_bar_fifo: directed stimulus with an expected-data queue checked by a decoupled output monitor.
module tb_bar_fifo;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk, rst;
    logic [31:0]   in_data, out_data;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] count;
`ifdef BAR_FIFO_STATS_EN
    logic [31:0]   stall_cnt;
`endif

    int ncmp = 0;
    int nfail = 0;
    logic [31:0] q[$];

    bar_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef BAR_FIFO_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // A transfer is committed at the next rising edge; check it mid-cycle.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            ncmp++;
            if (q.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_output: got %0d expected no output", out_data);
            end else begin
                logic [31:0] e;
                e = q.pop_front();
                if (out_data !== e) begin
                    nfail++;
                    $display("FAIL out_data_order: got %0d expected %0d", out_data, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_out_data", out_data, 0);

        q.push_back(42);
        cyc(1, 42, 0);
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data", out_data, 42);
        chk("single_count", 32'(count), 1);
        cyc(0, 0, 1);
        chk("single_drain_count", 32'(count), 0);
        chk("single_drain_data", out_data, 0);

        for (int i = 1; i <= 4; i++) begin
            q.push_back(32'(i));
            cyc(1, 32'(i), 0);
        end
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        cyc(1, 5, 0);
        chk("full_reject_count", 32'(count), 4);
        cyc(1, 5, 1);
        chk("full_pop_no_push_count", 32'(count), 3);
        chk("in_ready_after_pop", 32'(in_ready), 1);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1);
        chk("drain_count", 32'(count), 0);
        chk("drain_valid", 32'(out_valid), 0);

        for (int i = 0; i < 20; i++) begin
            q.push_back(32'(i));
            cyc(1, 32'(i), 1);
            chk("stream_count", 32'(count), 1);
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_latency_data", out_data, 32'(i));
        end
        cyc(0, 0, 1);
        chk("stream_end_count", 32'(count), 0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                q.push_back(32'(9001 + r * 4 + k));
                cyc(1, 32'(9001 + r * 4 + k), 0);
            end
            chk("wrap_full_count", 32'(count), 4);
            for (int k = 0; k < 4; k++)
                cyc(0, 0, 1);
            chk("wrap_empty_count", 32'(count), 0);
        end

        cyc(1, 1337, 0);
        cyc(1, 7, 0);
        rst = 1'b1;
        cyc(1, 9, 0);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        cyc(0, 0, 1);
        chk("after_midrst_count", 32'(count), 0);
        chk("after_midrst_valid", 32'(out_valid), 0);
        chk("after_midrst_in_ready", 32'(in_ready), 1);
        cyc(0, 0, 1);
        q.push_back(77);
        cyc(1, 77, 0);
        chk("after_midrst_push_data", out_data, 77);
        cyc(0, 0, 1);

`ifdef BAR_FIFO_STATS_EN
        rst = 1'b1;
        cyc(0, 0, 0);
        rst = 1'b0;
        #1;
        chk("stall_cleared", stall_cnt, 0);
        q.push_back(1);
        cyc(1, 1, 0);
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0);
        chk("stall_cnt_5", stall_cnt, 5);
        cyc(0, 0, 1);
        chk("stall_cnt_hold", stall_cnt, 5);
        rst = 1'b1;
        cyc(0, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0);
        chk("stall_cnt_rst", stall_cnt, 0);
`endif

        chk("scoreboard_empty", 32'(q.size()), 0);
        chk("final_valid", 32'(out_valid), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
